// File: rtl/xbar_pkg.sv
// rtl/xbar_pkg.sv - shared types and constants for the two-master slave arbiter
package xbar_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_GRANT0 = 2'd1,
      ST_GRANT1 = 2'd2
   } state_t;

   localparam logic        CMD_WRITE       = 1'b1;
   localparam logic        CMD_READ        = 1'b0;
   localparam int          ADDR_W          = 32;
   localparam int          DATA_W          = 32;
   localparam logic [31:0] ERR_RDATA       = 32'hDEAD_BEEF;
   localparam int          TIMEOUT_DEFAULT = 16;
   localparam int          CNT_W           = 16;

   // Counter value at which the last permitted GRANT cycle is reached.
   function automatic logic [CNT_W-1:0] timeout_last(input int timeout);
      return CNT_W'(timeout - 1);
   endfunction

endpackage

// File: rtl/xbar_slave_arbiter_if.sv
// rtl/xbar_slave_arbiter_if.sv - master/slave bus bundle around the arbiter
interface xbar_slave_arbiter_if;
   import xbar_pkg::*;

   logic              m0_req;
   logic [ADDR_W-1:0] m0_addr;
   logic              m0_cmd;
   logic [DATA_W-1:0] m0_wdata;
   logic              m0_ack;
   logic [DATA_W-1:0] m0_rdata;

   logic              m1_req;
   logic [ADDR_W-1:0] m1_addr;
   logic              m1_cmd;
   logic [DATA_W-1:0] m1_wdata;
   logic              m1_ack;
   logic [DATA_W-1:0] m1_rdata;

   logic              s_req;
   logic [ADDR_W-1:0] s_addr;
   logic              s_cmd;
   logic [DATA_W-1:0] s_wdata;
   logic              s_ack;
   logic [DATA_W-1:0] s_rdata;

   logic              timeout_err;

   // Arbiter view
   modport slave (
      input  m0_req, m0_addr, m0_cmd, m0_wdata,
      output m0_ack, m0_rdata,
      input  m1_req, m1_addr, m1_cmd, m1_wdata,
      output m1_ack, m1_rdata,
      output s_req, s_addr, s_cmd, s_wdata,
      input  s_ack, s_rdata,
      output timeout_err
   );

   // Environment view: masters and the shared slave
   modport master (
      output m0_req, m0_addr, m0_cmd, m0_wdata,
      input  m0_ack, m0_rdata,
      output m1_req, m1_addr, m1_cmd, m1_wdata,
      input  m1_ack, m1_rdata,
      input  s_req, s_addr, s_cmd, s_wdata,
      output s_ack, s_rdata,
      input  timeout_err
   );

endinterface

// File: rtl/xbar_rr_pick.sv
// rtl/xbar_rr_pick.sv - two-way round-robin choice between master requests
module xbar_rr_pick (
   input  logic [1:0] i_req,
   input  logic       i_last,
   output logic       o_grant
);

   // On a tie the master that did not win last time goes next.
   always_comb begin
      o_grant = 1'b0;
      if (i_req == 2'b11) begin
         o_grant = ~i_last;
      end else if (i_req[1]) begin
         o_grant = 1'b1;
      end
   end

endmodule

// File: rtl/xbar_slave_arbiter.sv
// rtl/xbar_slave_arbiter.sv - arbitrates two masters onto one slave with timeout
module xbar_slave_arbiter
   import xbar_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic                 clk,
   input  logic                 reset,
   xbar_slave_arbiter_if.slave  bus
);

   localparam logic [CNT_W-1:0] TO_LAST = timeout_last(TIMEOUT);

   state_t            r_state;
   logic              r_last;
   logic [CNT_W-1:0]  r_cnt;

   state_t            w_next;
   logic              w_pick;
   logic              w_sel;
   logic              w_req_x;
   logic              w_cmd_x;
   logic [ADDR_W-1:0] w_addr_x;
   logic [DATA_W-1:0] w_wdata_x;
   logic              w_s_req;
   logic              w_ack;
   logic [DATA_W-1:0] w_rdata;
   logic              w_terr;

   xbar_rr_pick u_pick (
      .i_req   ({bus.m1_req, bus.m0_req}),
      .i_last  (r_last),
      .o_grant (w_pick)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_last  <= 1'b1;
      end else begin
         r_state <= w_next;
         if (r_state == ST_IDLE && w_next != ST_IDLE) begin
            r_last <= w_pick;
            r_cnt  <= '0;
         end else if (r_state != ST_IDLE && !bus.s_ack) begin
            r_cnt  <= r_cnt + CNT_W'(1);
         end
      end
   end

   always_comb begin
      w_next    = r_state;
      w_sel     = 1'b0;
      w_req_x   = 1'b0;
      w_cmd_x   = 1'b0;
      w_addr_x  = '0;
      w_wdata_x = '0;
      w_s_req   = 1'b0;
      w_ack     = 1'b0;
      w_rdata   = '0;
      w_terr    = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (bus.m0_req || bus.m1_req) begin
               w_next = w_pick ? ST_GRANT1 : ST_GRANT0;
            end
         end
         ST_GRANT0, ST_GRANT1: begin
            w_sel     = (r_state == ST_GRANT1);
            w_req_x   = w_sel ? bus.m1_req   : bus.m0_req;
            w_cmd_x   = w_sel ? bus.m1_cmd   : bus.m0_cmd;
            w_addr_x  = w_sel ? bus.m1_addr  : bus.m0_addr;
            w_wdata_x = w_sel ? bus.m1_wdata : bus.m0_wdata;
            w_s_req   = w_req_x;
            w_rdata   = bus.s_rdata;
            // Completion beats abort, abort beats timeout.
            if (bus.s_ack) begin
               w_ack  = 1'b1;
               w_next = ST_IDLE;
            end else if (!w_req_x) begin
               w_next = ST_IDLE;
            end else if (r_cnt == TO_LAST) begin
               w_ack   = 1'b1;
               w_rdata = ERR_RDATA;
               w_terr  = 1'b1;
               w_s_req = 1'b0;
               w_next  = ST_IDLE;
            end
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   // Outputs are held low while reset is asserted, even mid-transaction.
   assign bus.s_req       = !reset && w_s_req;
   assign bus.s_cmd       = !reset && w_cmd_x;
   assign bus.s_addr      = reset ? '0 : w_addr_x;
   assign bus.s_wdata     = reset ? '0 : w_wdata_x;
   assign bus.m0_ack      = !reset && !w_sel && w_ack;
   assign bus.m1_ack      = !reset &&  w_sel && w_ack;
   assign bus.m0_rdata    = (reset || w_sel || r_state == ST_IDLE) ? '0 : w_rdata;
   assign bus.m1_rdata    = (reset || !w_sel) ? '0 : w_rdata;
   assign bus.timeout_err = !reset && w_terr;

endmodule

// File: tb/tb_xbar_slave_arbiter.sv
// tb/tb_xbar_slave_arbiter.sv - directed vector bench for xbar_slave_arbiter
module tb_xbar_slave_arbiter;
   import xbar_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   xbar_slave_arbiter_if bus();

   xbar_slave_arbiter #(.TIMEOUT(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic        rst;
      logic        m0_req, m0_cmd;
      logic [31:0] m0_addr, m0_wdata;
      logic        m1_req, m1_cmd;
      logic [31:0] m1_addr, m1_wdata;
      logic        s_ack;
      logic [31:0] s_rdata;
      logic [132:0] exp;
   } vec_t;

   vec_t vecs[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   function automatic void add(
      input logic rst,
      input logic m0r, m0c, input logic [31:0] m0a, m0w,
      input logic m1r, m1c, input logic [31:0] m1a, m1w,
      input logic sa, input logic [31:0] sr,
      input logic esr, esc, input logic [31:0] esa, esw,
      input logic ea0, input logic [31:0] er0,
      input logic ea1, input logic [31:0] er1,
      input logic et);
      vec_t v;
      v.rst = rst;
      v.m0_req = m0r; v.m0_cmd = m0c; v.m0_addr = m0a; v.m0_wdata = m0w;
      v.m1_req = m1r; v.m1_cmd = m1c; v.m1_addr = m1a; v.m1_wdata = m1w;
      v.s_ack = sa; v.s_rdata = sr;
      v.exp = {esr, esc, esa, esw, ea0, er0, ea1, er1, et};
      vecs.push_back(v);
   endfunction

   function automatic logic [132:0] outs();
      return {bus.s_req, bus.s_cmd, bus.s_addr, bus.s_wdata, bus.m0_ack, bus.m0_rdata,
              bus.m1_ack, bus.m1_rdata, bus.timeout_err};
   endfunction

   task automatic check(input string name, input logic [132:0] act, input logic [132:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      reset        = v.rst;
      bus.m0_req   = v.m0_req;  bus.m0_cmd = v.m0_cmd;
      bus.m0_addr  = v.m0_addr; bus.m0_wdata = v.m0_wdata;
      bus.m1_req   = v.m1_req;  bus.m1_cmd = v.m1_cmd;
      bus.m1_addr  = v.m1_addr; bus.m1_wdata = v.m1_wdata;
      bus.s_ack    = v.s_ack;   bus.s_rdata = v.s_rdata;
   endtask

   localparam logic [31:0] Z = 32'h0;
   localparam logic W = CMD_WRITE;
   localparam logic R = CMD_READ;

   int          n_cyc;
   logic [31:0] rd_seen;
   logic        te_seen;
   logic        m0_ack_seen;

   initial begin
      bus.m0_req = 0; bus.m0_cmd = 0; bus.m0_addr = Z; bus.m0_wdata = Z;
      bus.m1_req = 0; bus.m1_cmd = 0; bus.m1_addr = Z; bus.m1_wdata = Z;
      bus.s_ack = 0; bus.s_rdata = Z;

      //  rst  m0: req cmd addr wdata        m1: req cmd addr wdata       s_ack rdata        | s_req cmd addr wdata        m0 ack rdata          m1 ack rdata        terr
      add(1, 1,W,32'h4,32'h1234,        1,R,32'h8,Z,               1,32'h5,            0,0,Z,Z,                    0,Z,            0,Z,            0); // reset gates outputs
      add(1, 0,R,Z,Z,                   0,R,Z,Z,                   0,Z,                0,0,Z,Z,                    0,Z,            0,Z,            0);
      add(0, 1,W,32'h4,32'h1234,        0,R,Z,Z,                   0,Z,                0,0,Z,Z,                    0,Z,            0,Z,            0); // write seen in IDLE
      add(0, 1,W,32'h4,32'h1234,        0,R,Z,Z,                   0,Z,                1,1,32'h4,32'h1234,         0,Z,            0,Z,            0); // s_req next cycle
      add(0, 1,W,32'h4,32'h1234,        0,R,Z,Z,                   1,Z,                1,1,32'h4,32'h1234,         1,Z,            0,Z,            0); // ack
      add(0, 0,R,Z,Z,                   0,R,Z,Z,                   1,32'h99,           0,0,Z,Z,                    0,Z,            0,Z,            0); // s_ack ignored in IDLE
      add(1, 0,R,Z,Z,                   0,R,Z,Z,                   0,Z,                0,0,Z,Z,                    0,Z,            0,Z,            0);
      add(0, 1,R,32'h10,Z,              1,W,32'h20,32'hAAAA,       0,Z,                0,0,Z,Z,                    0,Z,            0,Z,            0); // tie after reset
      add(0, 1,R,32'h10,Z,              1,W,32'h20,32'hAAAA,       1,32'h11112222,     1,0,32'h10,Z,               1,32'h11112222, 0,Z,            0); // m0 wins
      add(0, 0,R,Z,Z,                   1,W,32'h20,32'hAAAA,       0,Z,                0,0,Z,Z,                    0,Z,            0,Z,            0); // bubble
      add(0, 0,R,Z,Z,                   1,W,32'h20,32'hAAAA,       0,Z,                1,1,32'h20,32'hAAAA,        0,Z,            0,Z,            0); // m1 granted
      add(0, 0,R,Z,Z,                   1,W,32'h20,32'hAAAA,       1,Z,                1,1,32'h20,32'hAAAA,        0,Z,            1,Z,            0);
      add(0, 0,R,Z,Z,                   1,R,32'h30,Z,              0,Z,                0,0,Z,Z,                    0,Z,            0,Z,            0); // m1 read
      add(0, 0,R,Z,Z,                   1,R,32'h30,Z,              1,32'hCAFE0001,     1,0,32'h30,Z,               0,Z,            1,32'hCAFE0001, 0);
      add(0, 0,R,Z,Z,                   0,R,Z,Z,                   0,Z,                0,0,Z,Z,                    0,Z,            0,Z,            0);
      add(0, 1,R,32'h40,Z,              0,R,Z,Z,                   0,Z,                0,0,Z,Z,                    0,Z,            0,Z,            0); // timeout run
      add(0, 1,R,32'h40,Z,              0,R,Z,Z,                   0,Z,                1,0,32'h40,Z,               0,Z,            0,Z,            0);
      add(0, 1,R,32'h40,Z,              0,R,Z,Z,                   0,Z,                1,0,32'h40,Z,               0,Z,            0,Z,            0);
      add(0, 1,R,32'h40,Z,              0,R,Z,Z,                   0,Z,                1,0,32'h40,Z,               0,Z,            0,Z,            0);
      add(0, 1,R,32'h40,Z,              0,R,Z,Z,                   0,Z,                0,0,32'h40,Z,               1,ERR_RDATA,    0,Z,            1); // 4th GRANT cycle
      add(0, 0,R,Z,Z,                   0,R,Z,Z,                   0,Z,                0,0,Z,Z,                    0,Z,            0,Z,            0);
      add(0, 1,R,32'h50,Z,              0,R,Z,Z,                   0,Z,                0,0,Z,Z,                    0,Z,            0,Z,            0); // ack on timeout cycle
      add(0, 1,R,32'h50,Z,              0,R,Z,Z,                   0,Z,                1,0,32'h50,Z,               0,Z,            0,Z,            0);
      add(0, 1,R,32'h50,Z,              0,R,Z,Z,                   0,Z,                1,0,32'h50,Z,               0,Z,            0,Z,            0);
      add(0, 1,R,32'h50,Z,              0,R,Z,Z,                   0,Z,                1,0,32'h50,Z,               0,Z,            0,Z,            0);
      add(0, 1,R,32'h50,Z,              0,R,Z,Z,                   1,32'h77,           1,0,32'h50,Z,               1,32'h77,       0,Z,            0);
      add(0, 0,R,Z,Z,                   0,R,Z,Z,                   0,Z,                0,0,Z,Z,                    0,Z,            0,Z,            0);
      add(0, 1,R,32'h60,Z,              0,R,Z,Z,                   0,Z,                0,0,Z,Z,                    0,Z,            0,Z,            0); // abort
      add(0, 1,R,32'h60,Z,              0,R,Z,Z,                   0,Z,                1,0,32'h60,Z,               0,Z,            0,Z,            0);
      add(0, 0,R,32'h60,Z,              0,R,Z,Z,                   0,Z,                0,0,32'h60,Z,               0,Z,            0,Z,            0); // req dropped, no ack
      add(0, 1,R,32'h60,Z,              1,R,32'h70,Z,              0,Z,                0,0,Z,Z,                    0,Z,            0,Z,            0); // tie: last still m0
      add(0, 1,R,32'h60,Z,              1,R,32'h70,Z,              0,Z,                1,0,32'h70,Z,               0,Z,            0,Z,            0); // m1 granted
      add(1, 1,R,32'h60,Z,              1,R,32'h70,Z,              1,32'h123,          0,0,Z,Z,                    0,Z,            0,Z,            0); // reset in GRANT1
      add(0, 1,R,32'h60,Z,              1,R,32'h70,Z,              0,Z,                0,0,Z,Z,                    0,Z,            0,Z,            0);
      add(0, 1,R,32'h60,Z,              1,R,32'h70,Z,              0,Z,                1,0,32'h60,Z,               0,Z,            0,Z,            0); // last reset to 1 -> m0
      add(0, 1,R,32'h60,Z,              1,R,32'h70,Z,              1,Z,                1,0,32'h60,Z,               1,Z,            0,Z,            0);
      add(0, 0,R,Z,Z,                   0,R,Z,Z,                   0,Z,                0,0,Z,Z,                    0,Z,            0,Z,            0);

      foreach (vecs[i]) begin
         @(posedge clk); #1;
         apply(vecs[i]);
         @(negedge clk);
         check($sformatf("vec%0d", i), outs(), vecs[i].exp);
      end

      // m1 timeout measured against a bounded cycle budget
      @(posedge clk); #1;
      bus.m1_req = 1; bus.m1_cmd = R; bus.m1_addr = 32'h80; bus.s_ack = 0; bus.s_rdata = Z;
      @(negedge clk);
      check("m1_to_idle", {132'h0, bus.s_req}, 133'h0);
      n_cyc = 0; rd_seen = Z; te_seen = 0; m0_ack_seen = 0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         m0_ack_seen = m0_ack_seen | bus.m0_ack;
         if (bus.m1_ack) begin
            n_cyc = c; rd_seen = bus.m1_rdata; te_seen = bus.timeout_err;
            break;
         end
      end
      check("m1_to_cycles", 133'(n_cyc), 133'(4));
      check("m1_to_rdata", {101'h0, rd_seen}, {101'h0, ERR_RDATA});
      check("m1_to_err", {132'h0, te_seen}, 133'h1);
      check("m1_to_m0ack", {132'h0, m0_ack_seen}, 133'h0);
      @(posedge clk); #1;
      bus.m1_req = 0;
      @(negedge clk);
      check("m1_to_after", outs(), 133'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
